// File: rtl/gps_lcode_serializer.sv
// gps_lcode_serializer: buffers 128-bit L-code words in a small FIFO and emits them as a
// rate-limited serial chip stream with valid/ready handshake and sticky overrun flag.
module gps_lcode_serializer #(
    parameter int WORD_W    = 128,
    parameter int DEPTH     = 2,
    parameter int CHIP_DIV  = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       sys_clk_50,
    input  logic                       sync_rst_in,
    input  logic [WORD_W-1:0]          l_code,
    input  logic                       l_code_valid,
    input  logic                       flush,
    input  logic                       chip_ready,
    output logic                       chip_out,
    output logic                       chip_valid,
    output logic                       word_first,
    output logic                       word_last,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow,
    output logic [15:0]                words_sent
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    localparam int DW = CHIP_DIV > 1 ? $clog2(CHIP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t            state, state_nx;
    logic              valid_q;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bit_idx;
    logic [DW-1:0]     div_cnt;
    logic              push_req, push, pop, xfer, last;

    assign fill_level = count;

    always_comb begin
        push_req   = l_code_valid && !valid_q;
        pop        = state == LOAD;
        push       = push_req && !flush && (count < CW'(DEPTH) || pop);
        chip_valid = state == SHIFT && div_cnt == '0;
        xfer       = chip_valid && chip_ready;
        last       = bit_idx == BW'(WORD_W - 1);
        word_first = chip_valid && bit_idx == '0;
        word_last  = chip_valid && last;
        chip_out   = MSB_FIRST ? shreg[WORD_W-1] : shreg[0];
        state_nx   = flush ? IDLE :
                     state == IDLE ? (count != '0 ? LOAD : IDLE) :
                     state == LOAD ? SHIFT :
                     (xfer && last) ? (count != '0 ? LOAD : IDLE) : SHIFT;
    end

    always_ff @(posedge sys_clk_50)
        if (push) mem[wr_ptr] <= l_code;

    always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
        if (sync_rst_in) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
            words_sent <= '0;
        end else begin
            state   <= state_nx;
            valid_q <= l_code_valid;
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                shreg    <= '0;
                bit_idx  <= '0;
                div_cnt  <= '0;
            end else begin
                if (push_req && !push) overflow <= 1'b1;
                if (push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
                if (push && !pop) count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
                // a pop always coincides with LOAD, so it owns the shifter on that edge
                if (pop) begin
                    shreg   <= mem[rd_ptr];
                    bit_idx <= '0;
                    div_cnt <= '0;
                end else if (xfer) begin
                    shreg   <= MSB_FIRST ? {shreg[WORD_W-2:0], 1'b0} : {1'b0, shreg[WORD_W-1:1]};
                    bit_idx <= last ? '0 : bit_idx + 1'b1;
                    div_cnt <= DW'(CHIP_DIV - 1);
                    if (last) words_sent <= words_sent + 16'd1;
                end else if (div_cnt != '0) begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gps_lcode_serializer.sv
// tb_gps_lcode_serializer: directed checks of capture, pacing, backpressure, overflow, flush
// and async reset; dut0 uses CHIP_DIV=4, dut1 uses CHIP_DIV=1.
module tb_gps_lcode_serializer;
    localparam logic [127:0] W_A = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] W_B = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
    localparam logic [127:0] W_C = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] W_D = 128'h5555AAAA_3333CCCC_0000FFFF_12345678;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] l_code = '0;
    logic         l_code_valid0 = 1'b0, l_code_valid1 = 1'b0;
    logic         flush = 1'b0;
    logic         chip_ready = 1'b0;
    logic         chip_out0, chip_valid0, word_first0, word_last0, overflow0;
    logic         chip_out1, chip_valid1, word_first1, word_last1, overflow1;
    logic [1:0]   fill_level0, fill_level1;
    logic [15:0]  words_sent0, words_sent1;
    logic         sel = 1'b0;
    logic         cv, co, wf, wl;
    int           total = 0;
    int           bad = 0;

    gps_lcode_serializer dut0 (
        .sys_clk_50(clk), .sync_rst_in(rst), .l_code(l_code), .l_code_valid(l_code_valid0),
        .flush(flush), .chip_ready(chip_ready), .chip_out(chip_out0), .chip_valid(chip_valid0),
        .word_first(word_first0), .word_last(word_last0), .fill_level(fill_level0),
        .overflow(overflow0), .words_sent(words_sent0)
    );

    gps_lcode_serializer #(.CHIP_DIV(1)) dut1 (
        .sys_clk_50(clk), .sync_rst_in(rst), .l_code(l_code), .l_code_valid(l_code_valid1),
        .flush(flush), .chip_ready(chip_ready), .chip_out(chip_out1), .chip_valid(chip_valid1),
        .word_first(word_first1), .word_last(word_last1), .fill_level(fill_level1),
        .overflow(overflow1), .words_sent(words_sent1)
    );

    assign cv = sel ? chip_valid1 : chip_valid0;
    assign co = sel ? chip_out1 : chip_out0;
    assign wf = sel ? word_first1 : word_first0;
    assign wl = sel ? word_last1 : word_last0;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receives n chips of w with chip_ready=1; first_gap<0 skips the chip-0 gap check.
    task automatic recv_word(input logic [127:0] w, input int first_gap, input int gap,
                             input int stall_at, input int n, input string tag);
        int  bad_bit = 0, bad_flag = 0, bad_gap = 0, bad_hold = 0, waited;
        logic c0, f0, l0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!cv && waited < 20) begin
                tick();
                waited++;
            end
            if (!cv) begin
                chk({tag, "_timeout"}, 32'(cv), 1);
                return;
            end
            if (i == 0 ? (first_gap >= 0 && waited != first_gap) : waited != gap) bad_gap++;
            if (co !== w[127-i]) bad_bit++;
            if (wf !== (i == 0) || wl !== (i == 127)) bad_flag++;
            if (i == stall_at) begin
                chip_ready = 1'b0;
                c0 = co;
                f0 = wf;
                l0 = wl;
                repeat (10) begin
                    tick();
                    if (cv !== 1'b1 || co !== c0 || wf !== f0 || wl !== l0) bad_hold++;
                end
                chip_ready = 1'b1;
            end
            tick();
        end
        chk({tag, "_bits"}, 32'(bad_bit), 0);
        chk({tag, "_flags"}, 32'(bad_flag), 0);
        chk({tag, "_gaps"}, 32'(bad_gap), 0);
        if (stall_at >= 0) chk({tag, "_hold"}, 32'(bad_hold), 0);
    endtask

    initial begin
        int n_chips, n_first, max_fill;
        #1;
        chk("rst_cv", 32'(chip_valid0), 0);
        chk("rst_fill", 32'(fill_level0), 0);
        chk("rst_ovf", 32'(overflow0), 0);
        chk("rst_ws", 32'(words_sent0), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single word, CHIP_DIV=4, chip_valid 2 cycles after the capture edge
        chip_ready = 1'b1;
        l_code = W_A;
        l_code_valid0 = 1'b1;
        tick();
        l_code_valid0 = 1'b0;
        chk("t2_fill", 32'(fill_level0), 1);
        recv_word(W_A, 2, 3, -1, 128, "t2");
        chk("t2_ws", 32'(words_sent0), 1);

        // backpressure at chip 40
        l_code = W_B;
        l_code_valid0 = 1'b1;
        tick();
        l_code_valid0 = 1'b0;
        recv_word(W_B, 2, 3, 40, 128, "t3");
        chk("t3_ws", 32'(words_sent0), 2);

        // filling the FIFO behind a stalled shifter, overflow, flush
        chip_ready = 1'b0;
        l_code = W_C;
        l_code_valid0 = 1'b1;
        tick();
        l_code_valid0 = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_shift_fill", 32'(fill_level0), 0);
        chk("t4_shift_cv", 32'(chip_valid0), 1);
        l_code_valid0 = 1'b1;
        tick();
        l_code_valid0 = 1'b0;
        chk("t4_fill1", 32'(fill_level0), 1);
        tick();
        l_code_valid0 = 1'b1;
        tick();
        l_code_valid0 = 1'b0;
        chk("t4_fill2", 32'(fill_level0), 2);
        chk("t4_ovf0", 32'(overflow0), 0);
        tick();
        l_code_valid0 = 1'b1;
        tick();
        l_code_valid0 = 1'b0;
        chk("t4_fill_full", 32'(fill_level0), 2);
        chk("t4_ovf1", 32'(overflow0), 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_fill", 32'(fill_level0), 0);
        chk("t4_flush_ovf", 32'(overflow0), 0);
        chk("t4_flush_cv", 32'(chip_valid0), 0);
        flush = 1'b1;
        l_code_valid0 = 1'b1;
        tick();
        flush = 1'b0;
        l_code_valid0 = 1'b0;
        chk("t4_fp_fill", 32'(fill_level0), 0);
        chk("t4_fp_ovf", 32'(overflow0), 0);
        tick();
        tick();
        chk("t4_fp_cv", 32'(chip_valid0), 0);
        chk("t4_ws_kept", 32'(words_sent0), 2);

        // level held high gives one word
        chip_ready = 1'b1;
        l_code = W_D;
        n_chips = 0;
        n_first = 0;
        max_fill = 0;
        for (int i = 0; i < 700; i++) begin
            l_code_valid0 = i < 50;
            if (chip_valid0) n_chips++;
            if (word_first0) n_first++;
            if (int'(fill_level0) > max_fill) max_fill = int'(fill_level0);
            tick();
        end
        l_code_valid0 = 1'b0;
        chk("t5_chips", 32'(n_chips), 128);
        chk("t5_firsts", 32'(n_first), 1);
        chk("t5_maxfill", 32'(max_fill), 1);
        chk("t5_ws", 32'(words_sent0), 3);

        // CHIP_DIV=1: two queued words, one LOAD bubble, then async reset mid-word
        sel = 1'b1;
        chip_ready = 1'b0;
        l_code = W_A;
        l_code_valid1 = 1'b1;
        tick();
        l_code_valid1 = 1'b0;
        tick();
        l_code = W_B;
        l_code_valid1 = 1'b1;
        tick();
        l_code_valid1 = 1'b0;
        tick();
        chk("t6_fill", 32'(fill_level1), 1);
        chip_ready = 1'b1;
        recv_word(W_A, -1, 0, -1, 128, "t6a");
        recv_word(W_B, 1, 0, -1, 128, "t6b");
        chk("t6_ws", 32'(words_sent1), 2);
        l_code = W_C;
        l_code_valid1 = 1'b1;
        tick();
        l_code_valid1 = 1'b0;
        recv_word(W_C, 2, 0, -1, 60, "t6c");
        chk("t6_pre_rst_cv", 32'(chip_valid1), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cv", 32'(chip_valid1), 0);
        chk("t6_rst_ws", 32'(words_sent1), 0);
        chk("t6_rst_fill", 32'(fill_level1), 0);
        chk("t6_rst_ovf", 32'(overflow1), 0);
        chk("t6_rst_ws0", 32'(words_sent0), 0);
        rst = 1'b0;
        tick();
        l_code = W_D;
        l_code_valid1 = 1'b1;
        tick();
        l_code_valid1 = 1'b0;
        recv_word(W_D, 2, 0, -1, 128, "t6d");
        chk("t6d_ws", 32'(words_sent1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
